// File: rtl/tensor_ram_reader_if.sv
// Bus bundle for tensor_ram_reader: the RAM read port and the byte output stream.
// The master side is the reader; the slave side is the RAM plus the downstream consumer.
interface tensor_ram_reader_if #(
    parameter int ADDR_BITS = 7,
    parameter int N_BITS    = 6,
    parameter int CH_BITS   = 7
);
    logic                 ram_read_en;
    logic [ADDR_BITS-1:0] ram_read_addr;
    logic [127:0]         ram_data_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic [N_BITS-1:0]    out_row;
    logic [N_BITS-1:0]    out_col;
    logic [CH_BITS-1:0]   out_channel;
    logic                 out_last;

    modport master (
        output ram_read_en, ram_read_addr,
        input  ram_data_in,
        output out_valid, out_data, out_row, out_col, out_channel, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_read_en, ram_read_addr,
        output ram_data_in,
        input  out_valid, out_data, out_row, out_col, out_channel, out_last,
        output out_ready
    );
endinterface

// File: rtl/tensor_ram_reader.sv
// tensor_ram_reader: walks a row-major, channel-last tensor in the banked
// 128-bit tensor RAM and streams it out one byte per valid/ready handshake,
// tagged with row/col/channel coordinates.
// Optional macro TENSOR_RAM_READER_PREFETCH_EN adds a spare word buffer so the
// next word is fetched while the current one streams (gapless at out_ready=1).
module tensor_ram_reader #(
    parameter int DEPTH_128B_WORDS = 128,
    parameter int ADDR_BITS        = $clog2(DEPTH_128B_WORDS),
    parameter int MAX_N            = 64,
    parameter int N_BITS           = $clog2(MAX_N),
    parameter int MAX_NUM_CH       = 64,
    parameter int CH_BITS          = $clog2(MAX_NUM_CH + 1),
    parameter int CNT_BITS         = $clog2(DEPTH_128B_WORDS * 16 + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [N_BITS-1:0]    cfg_num_rows,
    input  logic [N_BITS-1:0]    cfg_num_cols,
    input  logic [CH_BITS-1:0]   cfg_num_channels,
    output logic                 busy,
    output logic                 done,
    output logic                 err_oob,
    tensor_ram_reader_if.master  bus
);
    // Full product width so the bounds check never wraps, plus headroom for base*16.
    localparam int TOT_W = 2 * N_BITS + CH_BITS;
    localparam int CHK_W = TOT_W + ADDR_BITS + 5;
    localparam logic [CHK_W-1:0] RAM_BYTES = CHK_W'(DEPTH_128B_WORDS * 16);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_FETCH, S_WAIT, S_STREAM, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N_BITS-1:0]    rows_q, rows_d, cols_q, cols_d;
    logic [CH_BITS-1:0]   chans_q, chans_d;
    logic [N_BITS-1:0]    row_q, row_d, col_q, col_d;
    logic [CH_BITS-1:0]   chan_q, chan_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [CNT_BITS-1:0]  remain_q, remain_d;
    logic [3:0]           idx_q, idx_d;
    logic [127:0]         wbuf_q, wbuf_d;
    logic                 err_q, err_d;

    logic [TOT_W-1:0]     total;
    logic [CHK_W-1:0]     end_byte;
    logic                 tot_zero, oob, fire, last_byte, word_end, pf_issue;

`ifdef TENSOR_RAM_READER_PREFETCH_EN
    logic [127:0]         spare_q, spare_d;
    logic                 spare_full_q, spare_full_d;
    logic                 pend_q, pend_d;

    // Prefetch the following word at the start of each word, one read in flight at most.
    assign pf_issue = (state_q == S_STREAM) && (idx_q == 4'd0) && !spare_full_q
                      && !pend_q && (remain_q > CNT_BITS'(16));
`else
    assign pf_issue = 1'b0;
`endif

    // Tensor size, bounds check and handshake decode
    always_comb begin
        total     = TOT_W'(rows_q) * TOT_W'(cols_q) * TOT_W'(chans_q);
        end_byte  = (CHK_W'(waddr_q) << 4) + CHK_W'(total);
        tot_zero  = (total == '0);
        oob       = (end_byte > RAM_BYTES);
        fire      = (state_q == S_STREAM) && bus.out_ready;
        last_byte = (remain_q == CNT_BITS'(1));
        word_end  = (idx_q == 4'd15);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CALC;
            S_CALC:   state_d = (tot_zero || oob) ? S_DONE : S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   state_d = S_STREAM;
            S_STREAM: begin
                if (fire) begin
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else if (word_end) begin
`ifdef TENSOR_RAM_READER_PREFETCH_EN
                        state_d = spare_full_q ? S_STREAM : S_FETCH;
`else
                        state_d = S_FETCH;
`endif
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values: config latch, counters, word buffer(s)
    always_comb begin
        rows_d   = rows_q;
        cols_d   = cols_q;
        chans_d  = chans_q;
        row_d    = row_q;
        col_d    = col_q;
        chan_d   = chan_q;
        waddr_d  = waddr_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        wbuf_d   = wbuf_q;
        err_d    = err_q;
`ifdef TENSOR_RAM_READER_PREFETCH_EN
        spare_d      = spare_q;
        spare_full_d = spare_full_q;
        pend_d       = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = cfg_num_rows;
                    cols_d  = cfg_num_cols;
                    chans_d = cfg_num_channels;
                    waddr_d = cfg_base_addr;
                end
            end
            S_CALC: begin
                err_d    = !tot_zero && oob;
                remain_d = CNT_BITS'(total);
                row_d    = '0;
                col_d    = '0;
                chan_d   = '0;
`ifdef TENSOR_RAM_READER_PREFETCH_EN
                spare_full_d = 1'b0;
                pend_d       = 1'b0;
`endif
            end
            S_WAIT: begin
                wbuf_d = bus.ram_data_in;
                idx_d  = 4'd0;
            end
            S_STREAM: begin
                if (fire) begin
                    remain_d = remain_q - CNT_BITS'(1);
                    idx_d    = idx_q + 4'd1;
                    if (chan_q == chans_q - CH_BITS'(1)) begin
                        chan_d = '0;
                        if (col_q == cols_q - N_BITS'(1)) begin
                            col_d = '0;
                            row_d = row_q + N_BITS'(1);
                        end else begin
                            col_d = col_q + N_BITS'(1);
                        end
                    end else begin
                        chan_d = chan_q + CH_BITS'(1);
                    end
                    if (word_end && !last_byte) begin
                        waddr_d = waddr_q + ADDR_BITS'(1);
`ifdef TENSOR_RAM_READER_PREFETCH_EN
                        if (spare_full_q) begin
                            wbuf_d       = spare_q;
                            spare_full_d = 1'b0;
                        end
`endif
                    end
                end
            end
            default: ;
        endcase
`ifdef TENSOR_RAM_READER_PREFETCH_EN
        if (pend_q) begin
            spare_d      = bus.ram_data_in;
            spare_full_d = 1'b1;
            pend_d       = 1'b0;
        end
        if (pf_issue) pend_d = 1'b1;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_q   <= '0;
            cols_q   <= '0;
            chans_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            chan_q   <= '0;
            waddr_q  <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            wbuf_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            chans_q  <= chans_d;
            row_q    <= row_d;
            col_q    <= col_d;
            chan_q   <= chan_d;
            waddr_q  <= waddr_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            wbuf_q   <= wbuf_d;
            err_q    <= err_d;
        end
    end

`ifdef TENSOR_RAM_READER_PREFETCH_EN
    // Spare word buffer and outstanding-read flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spare_q      <= '0;
            spare_full_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            spare_q      <= spare_d;
            spare_full_q <= spare_full_d;
            pend_q       <= pend_d;
        end
    end
`endif

    // Outputs decoded from state; everything idles at zero
    always_comb begin
        busy              = (state_q != S_IDLE);
        done              = (state_q == S_DONE);
        err_oob           = err_q;
        bus.ram_read_en   = 1'b0;
        bus.ram_read_addr = '0;
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.out_row       = '0;
        bus.out_col       = '0;
        bus.out_channel   = '0;
        bus.out_last      = 1'b0;
        if (state_q == S_FETCH) begin
            bus.ram_read_en   = 1'b1;
            bus.ram_read_addr = waddr_q;
        end else if (pf_issue) begin
            bus.ram_read_en   = 1'b1;
            bus.ram_read_addr = waddr_q + ADDR_BITS'(1);
        end
        if (state_q == S_STREAM) begin
            bus.out_valid   = 1'b1;
            bus.out_data    = wbuf_q[{idx_q, 3'b000} +: 8];
            bus.out_row     = row_q;
            bus.out_col     = col_q;
            bus.out_channel = chan_q;
            bus.out_last    = last_byte;
        end
    end
endmodule

// File: tb/tb_tensor_ram_reader.sv
// Randomized bench for tensor_ram_reader with a queue-based reference model.
module tb_tensor_ram_reader;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int NB    = 6;
    localparam int CB    = 7;
`ifdef TENSOR_RAM_READER_PREFETCH_EN
    localparam int WORD_GAP = 16;
`else
    localparam int WORD_GAP = 18;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [NB-1:0] cfg_num_rows = '0;
    logic [NB-1:0] cfg_num_cols = '0;
    logic [CB-1:0] cfg_num_channels = '0;
    logic          busy, done, err_oob;

    tensor_ram_reader_if #(.ADDR_BITS(AW), .N_BITS(NB), .CH_BITS(CB)) bus();

    tensor_ram_reader #(.DEPTH_128B_WORDS(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_num_rows     (cfg_num_rows),
        .cfg_num_cols     (cfg_num_cols),
        .cfg_num_channels (cfg_num_channels),
        .busy             (busy),
        .done             (done),
        .err_oob          (err_oob),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, data one cycle after the strobe
    logic [127:0] mem [DEPTH];
    logic [127:0] rd_data = '0;
    always @(posedge clk) if (bus.ram_read_en) rd_data <= mem[bus.ram_read_addr];
    assign bus.ram_data_in = rd_data;

    typedef struct {
        logic [7:0] d;
        int         row;
        int         col;
        int         ch;
        bit         last;
        int         idx;
    } exp_t;

    exp_t byte_q[$];
    exp_t acc_log[$];
    int   rd_q[$];
    int   rd_log[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    bit active = 0, done_seen = 0, first_pend = 0;
    int start_edge = 0, exp_done_cyc = 0, ready_mode = 0, last_word_cyc = -1, hs_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ready_at(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Compare process: every cycle, outputs against the model queues
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_read_en) begin
                if (rd_q.size() == 0) begin
                    chk("read_unexpected", 64'(bus.ram_read_addr), 64'hFFFF);
                end else begin
                    chk("read_addr", 64'(bus.ram_read_addr), 64'(rd_q[0]));
                    rd_log.push_back(int'(bus.ram_read_addr));
                    void'(rd_q.pop_front());
                end
            end else begin
                chk("addr_idle_zero", 64'(bus.ram_read_addr), 64'd0);
            end
            if (bus.out_valid) begin
                if (first_pend) begin
                    chk("first_valid_latency", 64'(cyc - start_edge), 64'd3);
                    first_pend = 0;
                end
                if (byte_q.size() == 0) begin
                    chk("valid_unexpected", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = byte_q[0];
                    chk($sformatf("byte%0d{data,row,col,ch,last}", e.idx),
                        64'({bus.out_data, bus.out_row, bus.out_col, bus.out_channel, bus.out_last}),
                        64'({e.d, NB'(e.row), NB'(e.col), CB'(e.ch), e.last}));
                    if (bus.out_ready) begin
                        if (e.idx % 16 == 0) begin
                            if (ready_mode == 0 && last_word_cyc >= 0)
                                chk("word_gap", 64'(cyc - last_word_cyc), 64'(WORD_GAP));
                            last_word_cyc = cyc;
                        end
                        if (e.last) exp_done_cyc = cyc + 1;
                        acc_log.push_back(e);
                        void'(byte_q.pop_front());
                        hs_count++;
                    end
                end
            end
            if (done) begin
                if (!active) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    chk("done_timing", 64'(cyc), 64'(exp_done_cyc));
                    chk("busy_in_done", 64'(busy), 64'd1);
                    done_seen = 1;
                end
            end
        end
    end

    // Build the expected byte stream and read sequence from the tensor layout
    task automatic prep(input int base, input int r, input int c, input int ch, output bit oob);
        int   total;
        exp_t e;
        total = r * c * ch;
        oob   = (total != 0) && (base * 16 + total > DEPTH * 16);
        byte_q.delete(); rd_q.delete(); rd_log.delete(); acc_log.delete();
        if (total != 0 && !oob) begin
            for (int i = 0; i < total; i++) begin
                e.d    = mem[base + i / 16][8 * (i % 16) +: 8];
                e.row  = i / (c * ch);
                e.col  = (i / ch) % c;
                e.ch   = i % ch;
                e.last = (i == total - 1);
                e.idx  = i;
                byte_q.push_back(e);
            end
            for (int w = 0; w <= (total - 1) / 16; w++) rd_q.push_back(base + w);
        end
    endtask

    task automatic launch(input int base, input int r, input int c, input int ch,
                          input int mode, input bit oob);
        ready_mode    = mode;
        done_seen     = 0;
        last_word_cyc = -1;
        hs_count      = 0;
        exp_done_cyc  = -100;
        @(posedge clk); #1;
        cfg_base_addr    = AW'(base);
        cfg_num_rows     = NB'(r);
        cfg_num_cols     = NB'(c);
        cfg_num_channels = CB'(ch);
        bus.out_ready    = ready_at(mode, 0);
        start            = 1'b1;
        active           = 1;
        first_pend       = (r * c * ch != 0) && !oob;
        @(posedge clk); #1;
        start_edge = cyc;
        start      = 1'b0;
        if (!first_pend) exp_done_cyc = start_edge + 1;
        // Config changes while busy must not disturb the transfer
        cfg_base_addr    = AW'($urandom);
        cfg_num_rows     = NB'($urandom);
        cfg_num_cols     = NB'($urandom);
        cfg_num_channels = CB'($urandom);
    endtask

    task automatic run_xfer(input int base, input int r, input int c, input int ch,
                            input int mode, input bit noise);
        bit oob;
        prep(base, r, c, ch, oob);
        launch(base, r, c, ch, mode, oob);
        for (int k = 1; k < 4000 && !done_seen; k++) begin
            bus.out_ready = ready_at(mode, k);
            start = noise && bus.out_valid && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_reached", 64'(done_seen), 64'd1);
        chk("bytes_left", 64'(byte_q.size()), 64'd0);
        chk("reads_left", 64'(rd_q.size()), 64'd0);
        chk("err_oob_end", 64'(err_oob), 64'(oob));
        chk("idle_after_done", 64'(busy), 64'd0);
        active = 0;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 64'({busy, done, err_oob, bus.out_valid, bus.ram_read_en, bus.ram_read_addr,
                       bus.out_data, bus.out_row, bus.out_col, bus.out_channel, bus.out_last}), 64'd0);
    endtask

    initial begin
        bit oob;
        bus.out_ready = 1'b1;
        for (int w = 0; w < DEPTH; w++) mem[w] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = 128'h0F0E0D0C0B0A09080706050403020100;
        for (int b = 0; b < 16; b++) mem[10][8 * b +: 8] = 8'hA0 + 8'(b);

        #1;
        check_all_zero("reset_outputs");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 1x1x4 from word 0
        run_xfer(0, 1, 1, 4, 0, 0);
        chk("t1_nbytes", 64'(acc_log.size()), 64'd4);
        if (acc_log.size() == 4) begin
            chk("t1_data", 64'({acc_log[3].d, acc_log[2].d, acc_log[1].d, acc_log[0].d}), 64'h03020100);
            chk("t1_chan", 64'({8'(acc_log[3].ch), 8'(acc_log[2].ch), 8'(acc_log[1].ch), 8'(acc_log[0].ch)}),
                64'h03020100);
            chk("t1_last", 64'({acc_log[3].last, acc_log[0].last}), 64'b10);
        end
        chk("t1_nreads", 64'(rd_log.size()), 64'd1);
        if (rd_log.size() == 1) chk("t1_read_addr", 64'(rd_log[0]), 64'd0);

        // 2x2x8 from word 3, full rate and then with a stall pattern
        run_xfer(3, 2, 2, 8, 0, 0);
        chk("t2_nreads", 64'(rd_log.size()), 64'd2);
        if (rd_log.size() == 2) chk("t2_read_addrs", 64'({8'(rd_log[0]), 8'(rd_log[1])}), 64'h0304);
        if (acc_log.size() == 32)
            chk("t2_last_coord", 64'({8'(acc_log[31].row), 8'(acc_log[31].col), 8'(acc_log[31].ch)}), 64'h010107);
        run_xfer(3, 2, 2, 8, 1, 0);
        chk("t3_nbytes", 64'(acc_log.size()), 64'd32);

        // Empty tensor
        run_xfer(5, 3, 3, 0, 0, 0);
        chk("t4_no_reads", 64'(rd_log.size()), 64'd0);

        // Out of bounds, then exact fit clears the flag
        run_xfer(127, 1, 1, 32, 0, 0);
        chk("t5_oob_sticky", 64'(err_oob), 64'd1);
        chk("t5_no_reads", 64'(rd_log.size()), 64'd0);
        run_xfer(126, 1, 1, 32, 0, 0);
        chk("t6_oob_cleared", 64'(err_oob), 64'd0);

        // Reset after 5 bytes of a 32-byte transfer
        prep(10, 1, 1, 32, oob);
        launch(10, 1, 1, 32, 0, oob);
        for (int k = 0; k < 200 && hs_count < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("t7_five_bytes", 64'(hs_count), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t7_reset_outputs");
        active = 0;
        first_pend = 0;
        byte_q.delete(); rd_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t7_idle_after_reset", 64'(busy), 64'd0);
        run_xfer(10, 1, 1, 32, 0, 0);
        if (acc_log.size() == 32)
            chk("t7_restart_first", 64'({acc_log[0].d, acc_log[5].d}), 64'hA0A5);
        if (rd_log.size() > 0) chk("t7_restart_addr", 64'(rd_log[0]), 64'd10);

        // Randomized transfers with random backpressure and spurious starts
        for (int t = 0; t < 14; t++) begin
            run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 2)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
